// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package cpu_mem_pkg;

    localparam int WORD_W              = 32;
    localparam int BE_W                = 4;
    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Misaligned or beyond-the-array byte address.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
        logic [WORD_W-1:0] word_s;
        word_s = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_s >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU load-store unit and the data memory responder.
interface dmem_responder_if;
    import cpu_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word array with a byte-enabled synchronous write port and a registered read port.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Byte-lane write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register: clear wins so stores and errors return zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= {WORD_W{1'b0}};
        end else if (rd_clr) begin
            rd_data <= {WORD_W{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed response latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range addresses; otherwise addresses wrap.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e       state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic [WORD_W-1:0] addr_r, wdata_r;
    logic              write_r;
    logic [BE_W-1:0]   be_r;
    logic              req_ready_r, rsp_valid_r, rsp_err_r;
    logic              accept_s, go_resp_s;
    logic [WORD_W-1:0] op_addr_s, op_wdata_s;
    logic              op_write_s;
    logic [BE_W-1:0]   op_be_s;
    logic              err_s;
    logic [IDX_W-1:0]  idx_s;
    logic              wr_en_s, rd_en_s, rd_clr_s;
    logic [WORD_W-1:0] rd_data_s;

    assign accept_s = (state_r == IDLE) && bus.req_valid && req_ready_r;

    // Next state; go_resp_s marks the edge on which the array is accessed
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        go_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && (WAIT_CYCLES > 0)) begin
                    state_s = WAIT;
                    cnt_s   = WAIT_LOAD;
                end else if (accept_s) begin
                    state_s   = RESP;
                    go_resp_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s   = RESP;
                    go_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // With zero wait the access happens on the accepting edge, so use the live request
    always_comb begin
        if (state_r == IDLE) begin
            op_addr_s  = bus.req_addr;
            op_wdata_s = bus.req_wdata;
            op_write_s = bus.req_write;
            op_be_s    = bus.req_be;
        end else begin
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
            op_write_s = write_r;
            op_be_s    = be_r;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    assign err_s = addr_err(op_addr_s, DEPTH_WORDS);
`else
    logic [WORD_W-IDX_W-1:0] addr_unused_s;
    assign err_s         = 1'b0;
    assign addr_unused_s = {op_addr_s[WORD_W-1:IDX_W+2], op_addr_s[1:0]};
`endif

    assign idx_s    = op_addr_s[IDX_W+1:2];
    assign wr_en_s  = go_resp_s && op_write_s && !err_s;
    assign rd_en_s  = go_resp_s && !op_write_s && !err_s;
    assign rd_clr_s = go_resp_s && (op_write_s || err_s);

    // State, wait counter, captured request and response flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {WORD_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            write_r     <= 1'b0;
            be_r        <= {BE_W{1'b0}};
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            // Ready only after a full idle cycle, which also blocks same-cycle re-accept
            req_ready_r <= (state_r == IDLE) && (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
            if (accept_s) begin
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                write_r <= bus.req_write;
                be_r    <= bus.req_be;
            end
            if (go_resp_s) begin
                rsp_err_r <= err_s;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_s),
        .wr_data (op_wdata_s),
        .wr_be   (op_be_s),
        .rd_en   (rd_en_s),
        .rd_clr  (rd_clr_s),
        .rd_idx  (idx_s),
        .rd_data (rd_data_s)
    );

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rd_data_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance checked every cycle against a
// transaction-level memory model, plus a WAIT_CYCLES=0 instance for latency and throughput.
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int WAITA = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncyc  = 0;
    int   tests = 0;
    int   fails = 0;

    dmem_responder_if busA ();
    dmem_responder_if busB ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITA)) dutA (.clk(clk), .rst(rst), .bus(busA));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0))     dutB (.clk(clk), .rst(rst), .bus(busB));

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    // Model: a word-addressed memory; one entry per instance keyed by inst*65536+index
    logic [31:0] mem_m [int];

    function automatic void model_txn(input int inst, input logic wr, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] be,
                                      output logic [31:0] rd, output logic er);
        int          idx;
        logic [31:0] w;
`ifdef DMEM_ERR_CHECK_EN
        er = (a % 4 != 0) || ((a / 4) >= DEPTH);
`else
        er = 1'b0;
`endif
        idx = inst * 65536 + int'((a / 4) % DEPTH);
        rd  = 32'h0;
        if (!er && wr) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
            mem_m[idx] = w;
        end else if (!er) begin
            rd = mem_m.exists(idx) ? mem_m[idx] : 32'hx;
        end
    endfunction

    typedef struct {logic [31:0] rd; logic er; int acc; int due;} exp_t;
    exp_t expq[$];

    // Per-cycle comparison of instance A against the outstanding expectation
    always @(negedge clk) begin
        if (rst && expq.size() == 0) begin
            check("rsp_valid_idle", 32'(busA.rsp_valid), 32'd0);
        end else if (rst) begin
            if (ncyc > expq[0].acc) check("req_ready_busy", 32'(busA.req_ready), 32'd0);
            if (ncyc < expq[0].due) begin
                check("rsp_valid_early", 32'(busA.rsp_valid), 32'd0);
            end else begin
                check("rsp_valid_due", 32'(busA.rsp_valid), 32'd1);
                check("rsp_rdata", busA.rsp_rdata, expq[0].rd);
                check("rsp_err", 32'(busA.rsp_err), 32'(expq[0].er));
                if (busA.rsp_valid && busA.rsp_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic start_a(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        busA.req_valid = 1'b1;
        busA.req_write = wr;
        busA.req_addr  = a;
        busA.req_wdata = wd;
        busA.req_be    = be;
    endtask

    task automatic accept_a(output int acc);
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        bit          got = 0;
        acc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busA.req_ready) begin
                got = 1;
                acc = ncyc;
                model_txn(0, busA.req_write, busA.req_addr, busA.req_wdata, busA.req_be, rd, er);
                e.rd = rd; e.er = er; e.acc = ncyc; e.due = ncyc + WAITA + 1;
                expq.push_back(e);
            end
            @(posedge clk); #1;
        end
        busA.req_valid = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_a(input int acc, output int lat, output logic [31:0] rd, output logic er);
        bit seen = 0;
        lat = -1; rd = 32'hx; er = 1'bx;
        for (int i = 0; i < 40 && expq.size() != 0; i++) begin
            @(negedge clk);
            if (busA.rsp_valid && !seen) begin
                seen = 1;
                lat  = ncyc - acc;
                rd   = busA.rsp_rdata;
                er   = busA.rsp_err;
            end
        end
        if (expq.size() != 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic txn_a(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
        int acc;
        start_a(wr, a, wd, be);
        accept_a(acc);
        finish_a(acc, lat, rd, er);
    endtask

    typedef struct {int cyc; logic [31:0] rd; logic er;} rsp_t;
    rsp_t rspq[$];

    // Collect instance B response handshakes
    always @(negedge clk) begin
        rsp_t r;
        if (rst && busB.rsp_valid && busB.rsp_ready) begin
            r.cyc = ncyc; r.rd = busB.rsp_rdata; r.er = busB.rsp_err;
            rspq.push_back(r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, acc, acc2, h;
        logic [31:0] rd, save;
        logic        er;
        bit          got;
        logic        b_wr [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] b_ad [6]  = '{32'h80, 32'h84, 32'h88, 32'h84, 32'h80, 32'h88};
        logic [31:0] b_wd [6]  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h0};
        int          b_acc [6];
        logic [31:0] b_erd [6];
        logic        b_eer [6];

        busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = 32'h0;
        busA.req_wdata = 32'h0; busA.req_be = 4'h0; busA.rsp_ready = 1'b1;
        busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = 32'h0;
        busB.req_wdata = 32'h0; busB.req_be = 4'h0; busB.rsp_ready = 1'b1;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(busA.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(busA.req_ready), 32'd0);
        check("rst_rdata", busA.rsp_rdata, 32'd0);
        check("rst_err", 32'(busA.rsp_err), 32'd0);
        check("rst_req_ready_b", 32'(busB.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(busA.req_ready), 32'd1);
        check("ready_after_rst_b", 32'(busB.req_ready), 32'd1);

        // Full-word store then load, with latency WAIT_CYCLES+1
        txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
        check("store_latency", 32'(lat), 32'd3);
        check("store_err", 32'(er), 32'd0);
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        check("load_latency", 32'(lat), 32'd3);
        check("load_deadbeef", rd, 32'hDEADBEEF);

        // Partial stores
        txn_a(1'b1, 32'h10, 32'h00000055, 4'h1, lat, rd, er);
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        check("load_be1", rd, 32'hDEADBE55);
        txn_a(1'b1, 32'h24, 32'h12345678, 4'hF, lat, rd, er);
        txn_a(1'b1, 32'h24, 32'hAABBCCDD, 4'hA, lat, rd, er);
        txn_a(1'b0, 32'h24, 32'h0, 4'h0, lat, rd, er);
        check("load_be_a", rd, 32'hAA34CC78);

        // Last word of the array
        txn_a(1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, lat, rd, er);
        txn_a(1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, er);
        check("load_last_word", rd, 32'h0BADF00D);
        txn_a(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat, rd, er);

        // Back-pressure: hold the response 5 cycles while a new request waits
        busA.rsp_ready = 1'b0;
        start_a(1'b0, 32'h24, 32'h0, 4'h0);
        accept_a(acc);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (busA.rsp_valid) got = 1;
        end
        if (!got) check("hold_rsp_timeout", 32'd0, 32'd1);
        check("hold_latency", 32'(ncyc - acc), 32'd3);
        start_a(1'b0, 32'h10, 32'h0, 4'h0);
        repeat (5) @(posedge clk);
        #1;
        busA.rsp_ready = 1'b1;
        h = ncyc;
        accept_a(acc2);
        check("reaccept_gap", 32'(acc2 - h), 32'd2);
        finish_a(acc2, lat, rd, er);
        check("load_after_hold", rd, 32'hDEADBE55);

`ifdef DMEM_ERR_CHECK_EN
        txn_a(1'b1, 32'h13, 32'h12121212, 4'hF, lat, rd, er);
        check("err_misaligned", 32'(er), 32'd1);
        check("err_misaligned_rdata", rd, 32'd0);
        txn_a(1'b1, 32'h400, 32'h34343434, 4'hF, lat, rd, er);
        check("err_range", 32'(er), 32'd1);
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        check("load_after_err", rd, 32'hDEADBE55);
`else
        txn_a(1'b0, 32'h410, 32'h0, 4'h0, lat, rd, er);
        check("load_wrap", rd, 32'hDEADBE55);
        check("load_wrap_err", 32'(er), 32'd0);
`endif

        // Reset one cycle after accepting a store: nothing commits
        save = mem_m[8];
        start_a(1'b1, 32'h20, 32'h11112222, 4'hF);
        accept_a(acc);
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(busA.rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(busA.req_ready), 32'd0);
        check("midrst_err", 32'(busA.rsp_err), 32'd0);
        expq.delete();
        mem_m[8] = save;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midrst", 32'(busA.req_ready), 32'd1);
        txn_a(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        check("load_after_midrst", rd, 32'hCAFEF00D);

        // Zero-wait instance: req_valid held high, rsp_ready tied high
        rspq.delete();
        for (int t = 0; t < 6; t++) begin
            busB.req_valid = 1'b1;
            busB.req_write = b_wr[t];
            busB.req_addr  = b_ad[t];
            busB.req_wdata = b_wd[t];
            busB.req_be    = 4'hF;
            got = 0;
            b_acc[t] = -1;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (busB.req_ready) begin
                    got = 1;
                    b_acc[t] = ncyc;
                    model_txn(1, b_wr[t], b_ad[t], b_wd[t], 4'hF, b_erd[t], b_eer[t]);
                end
                @(posedge clk); #1;
            end
            if (!got) check("b_accept_timeout", 32'd0, 32'd1);
        end
        busB.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("b_rsp_count", 32'(rspq.size()), 32'd6);
        for (int t = 0; t < 6 && t < rspq.size(); t++) begin
            check("b_latency", 32'(rspq[t].cyc - b_acc[t]), 32'd1);
            check("b_rdata", rspq[t].rd, b_erd[t]);
            check("b_err", 32'(rspq[t].er), 32'(b_eer[t]));
            if (t > 0) check("b_throughput", 32'(b_acc[t] - b_acc[t-1]), 32'd3);
        end
        if (rspq.size() > 3) check("b_load_84", rspq[3].rd, 32'h22222222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 Parameter WAIT_CYCLES, default 2, number of idle cycles inserted between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU presents a memory request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for stores; bit i covers bits 8i+7..8i; ignored for loads.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  CPU accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected (see REQ-026).

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; a request is accepted when req_valid && req_ready, and addr/write/wdata/be are captured into registers.
REQ-017 Acceptance transition: to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-018 WAIT: a down-counter loaded with WAIT_CYCLES-1 on acceptance; go to RESP when the counter equals 0, otherwise decrement.
REQ-019 Store commit: the array is written on the IDLE/WAIT-to-RESP transition, and only byte lanes with be=1 change.
REQ-020 Load: rsp_rdata is registered from the array on the same transition and reflects all earlier committed stores.
REQ-021 Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-022 RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid && rsp_ready.
REQ-023 On the response handshake: return to IDLE; req_ready=0 in that cycle, with no same-cycle re-accept.
REQ-024 req_ready=0 in WAIT and RESP; req_* inputs are ignored there.
REQ-025 Word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-026 rsp_err rules depend on DMEM_ERR_CHECK_EN (REQ-030/031); an errored store never modifies the array.

Reset
REQ-027 rst low, at any time including mid-transaction: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and captured request registers cleared.
REQ-028 While rst is low, req_ready=0; it goes to 1 on the first rising edge after rst deasserts.
REQ-029 Array contents are not reset; an interrupted store does not commit.

Configuration
REQ-030 With DMEM_ERR_CHECK_EN defined: rsp_err=1 when req_addr[1:0]!=0, or when req_addr[31:2] >= DEPTH_WORDS.
REQ-031 Without DMEM_ERR_CHECK_EN: rsp_err is tied 0, addr[1:0] is ignored, and the address wraps modulo DEPTH_WORDS.

Structure
REQ-032 Shared package cpu_mem_pkg holds the FSM state enum, WORD_W=32, BE_W=4 and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-033 Sub-module dmem_array: synchronous byte-enabled write port plus registered read port, instantiated once.

Verification
REQ-034 Reset, then store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10 -> each response arrives 3 cycles after acceptance (WAIT_CYCLES=2); load returns 0xDEADBEEF, err=0.
REQ-035 Store 0x10, wdata 0x00000055, be 0x1 over 0xDEADBEEF, then load 0x10 -> returns 0xDEADBE55.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a second req_valid is not accepted until the cycle after the handshake.
REQ-037 With DMEM_ERR_CHECK_EN: store to 0x13 and to 0x400 (DEPTH 256) -> rsp_err=1, rdata=0, and a subsequent load of 0x10 is unchanged. Without the macro: load 0x410 returns the word at 0x10.
REQ-038 Assert rst low one cycle after accepting a store to 0x20 -> rsp_valid=0 immediately; after release, a load of 0x20 returns the prior contents.
REQ-039 WAIT_CYCLES=0 -> rsp_valid rises 1 cycle after acceptance; back-to-back transactions sustain one transaction per 3 cycles with rsp_ready tied 1.
